// File: rtl/hazard_ctrl_fsm.sv
// hazard_ctrl_fsm: pipeline interlock controller for the 5-stage MIPS core.
// It handles forwarding selects, load-use and branch interlocks, a
// multi-cycle divide hold and an exception flush sequence. It also keeps a
// saturating count of the cycles in which D was stalled.
module hazard_ctrl_fsm #(
    parameter int REGW    = 5,
    parameter int DIV_LAT = 32,
    parameter int CNTW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [REGW-1:0] rsD,
    input  logic [REGW-1:0] rtD,
    input  logic            branchD,
    input  logic [REGW-1:0] rsE,
    input  logic [REGW-1:0] rtE,
    input  logic [REGW-1:0] writeregE,
    input  logic            regwriteE,
    input  logic            memtoregE,
    input  logic            div_startE,
    input  logic            hiloreadE,
    input  logic [REGW-1:0] writeregM,
    input  logic            regwriteM,
    input  logic            memtoregM,
    input  logic            hilowriteM,
    input  logic            excM,
    input  logic [REGW-1:0] writeregW,
    input  logic            regwriteW,
    input  logic            hilowriteW,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            stallW,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            forwardaD,
    output logic            forwardbD,
    output logic [1:0]      forwardaE,
    output logic [1:0]      forwardbE,
    output logic [1:0]      forwardhiloE,
    output logic            div_busy,
    output logic [CNTW-1:0] stall_cnt
);

    // The divide counter is at least 5 bits wide so that small latencies
    // keep the same counter layout as the default build.
    localparam int DCW = ($clog2(DIV_LAT) > 5) ? $clog2(DIV_LAT) : 5;
    localparam logic [DCW-1:0] DIV_LOAD = DCW'(DIV_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        FLUSH = 2'd2
    } stateT;

    stateT           stateReg;
    logic [DCW-1:0]  dcntReg;
    logic [CNTW-1:0] stallCntReg;

    // Register $0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic regMatch(input logic [REGW-1:0] a,
                                      input logic [REGW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

    // Source operands are indexed 0 = rs and 1 = rt in both D and E.
    logic [1:0][REGW-1:0] srcD;
    logic [1:0][REGW-1:0] srcE;
    logic [1:0][1:0]      fwdE;
    logic [1:0]           fwdD;
    logic [1:0]           hitE;
    logic [1:0]           hitLoadM;

    assign srcD = {rtD, rsD};
    assign srcE = {rtE, rsE};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            // M takes priority over W because it holds the younger result.
            assign fwdE[gi] = rst ? 2'b00 :
                              (regwriteM && regMatch(srcE[gi], writeregM)) ? 2'b10 :
                              (regwriteW && regMatch(srcE[gi], writeregW)) ? 2'b01 :
                              2'b00;
            assign fwdD[gi]     = !rst && regwriteM && regMatch(srcD[gi], writeregM);
            assign hitE[gi]     = regMatch(srcD[gi], writeregE);
            assign hitLoadM[gi] = regMatch(srcD[gi], writeregM);
        end
    endgenerate

    assign forwardaE = fwdE[0];
    assign forwardbE = fwdE[1];
    assign forwardaD = fwdD[0];
    assign forwardbD = fwdD[1];

    assign forwardhiloE = (rst || !hiloreadE) ? 2'b00 :
                          hilowriteM          ? 2'b10 :
                          hilowriteW          ? 2'b01 :
                          2'b00;

    logic lwStall;
    logic brStall;
    logic divStall;
    logic excActive;

    assign lwStall   = memtoregE && (|hitE);
    assign brStall   = branchD && ((regwriteE && (|hitE)) || (memtoregM && (|hitLoadM)));
    assign divStall  = ((stateReg == IDLE) && div_startE) ||
                       ((stateReg == DIV) && (dcntReg != '0));
    assign excActive = excM && (stateReg != FLUSH);

    // Stage stall/flush enables, highest priority first:
    // reset, exception, handler fetch, divide hold, then data interlocks.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (excActive) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (stateReg == FLUSH) begin
            stallF = 1'b1;
            flushD = 1'b1;
        end else if (divStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (lwStall || brStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    assign stallM    = 1'b0;
    assign stallW    = 1'b0;
    assign div_busy  = !rst && (stateReg == DIV);
    assign stall_cnt = stallCntReg;

    // Sequencer state, divide countdown and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            dcntReg     <= '0;
            stallCntReg <= '0;
        end else begin
            if (stallD && (stallCntReg != '1)) begin
                stallCntReg <= stallCntReg + 1'b1;
            end
            case (stateReg)
                IDLE: begin
                    if (excM) begin
                        stateReg <= FLUSH;
                    end else if (div_startE) begin
                        stateReg <= DIV;
                        dcntReg  <= DIV_LOAD;
                    end
                end
                DIV: begin
                    if (excM) begin
                        // The exception aborts the divide that is in flight.
                        stateReg <= FLUSH;
                        dcntReg  <= '0;
                    end else if (dcntReg != '0) begin
                        dcntReg <= dcntReg - 1'b1;
                    end else begin
                        stateReg <= IDLE;
                    end
                end
                FLUSH: begin
                    stateReg <= IDLE;
                end
                default: begin
                    stateReg <= IDLE;
                    dcntReg  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_fsm.sv
// Testbench for hazard_ctrl_fsm. It runs directed scenarios with literal
// expectations and then a randomized stream. A behavioural model, based on
// the remaining divide cycles and a pending-flush flag, is compared with the
// DUT outputs on every cycle.
module tb_hazard_ctrl_fsm;

    localparam int REGW    = 5;
    localparam int DIV_LAT = 4;
    localparam int CNTW    = 3;
    localparam int CNT_MAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [REGW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic            branchD, regwriteE, memtoregE, div_startE, hiloreadE;
    logic            regwriteM, memtoregM, hilowriteM, excM, regwriteW, hilowriteW;
    logic            stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM;
    logic            forwardaD, forwardbD, div_busy;
    logic [1:0]      forwardaE, forwardbE, forwardhiloE;
    logic [CNTW-1:0] stall_cnt;

    hazard_ctrl_fsm #(.REGW(REGW), .DIV_LAT(DIV_LAT), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
        .memtoregE(memtoregE), .div_startE(div_startE), .hiloreadE(hiloreadE),
        .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .hilowriteM(hilowriteM), .excM(excM),
        .writeregW(writeregW), .regwriteW(regwriteW), .hilowriteW(hilowriteW),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardhiloE(forwardhiloE),
        .div_busy(div_busy), .stall_cnt(stall_cnt)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: cycles of div_busy still to come, including the current one.
    int busyLeft = 0;
    bit inFlush  = 1'b0;
    int cntModel = 0;
    bit expStallD;

    function automatic bit dep(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] fwdSel(input logic [REGW-1:0] src, input logic [REGW-1:0] m,
                                          input logic wm, input logic [REGW-1:0] w, input logic ww);
        if (wm && dep(src, m)) return 2'b10;
        if (ww && dep(src, w)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic clearInputs();
        rst = 0; rsD = 0; rtD = 0; branchD = 0; rsE = 0; rtE = 0;
        writeregE = 0; regwriteE = 0; memtoregE = 0; div_startE = 0; hiloreadE = 0;
        writeregM = 0; regwriteM = 0; memtoregM = 0; hilowriteM = 0; excM = 0;
        writeregW = 0; regwriteW = 0; hilowriteW = 0;
    endtask

    task automatic lit(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc, got, want);
        end
    endtask

    // Settle the inputs, then compare every output with the model.
    task automatic step();
        bit sF, sD, sE, fD, fE, fM, exc, hazard, dBusy;
        logic [1:0] fa, fb, fh;
        logic [16:0] want, got;
        #4;
        sF = 0; sD = 0; sE = 0; fD = 0; fE = 0; fM = 0; dBusy = 0;
        fa = 0; fb = 0; fh = 0;
        exc    = excM && !inFlush;
        hazard = (memtoregE && (dep(rsD, writeregE) || dep(rtD, writeregE))) ||
                 (branchD && ((regwriteE && (dep(rsD, writeregE) || dep(rtD, writeregE))) ||
                              (memtoregM && (dep(rsD, writeregM) || dep(rtD, writeregM)))));
        if (rst) begin
            fD = 1; fE = 1; fM = 1;
        end else begin
            fa = fwdSel(rsE, writeregM, regwriteM, writeregW, regwriteW);
            fb = fwdSel(rtE, writeregM, regwriteM, writeregW, regwriteW);
            fh = !hiloreadE ? 2'b00 : hilowriteM ? 2'b10 : hilowriteW ? 2'b01 : 2'b00;
            dBusy = (busyLeft > 0);
            if (exc) begin
                fD = 1; fE = 1; fM = 1;
            end else if (inFlush) begin
                sF = 1; fD = 1;
            end else if ((busyLeft == 0 && div_startE) || busyLeft > 1) begin
                sF = 1; sD = 1; sE = 1; fM = 1;
            end else if (hazard) begin
                sF = 1; sD = 1; fE = 1;
            end
        end
        expStallD = sD;
        want = {sF, sD, sE, 1'b0, 1'b0, fD, fE, fM,
                !rst && regwriteM && dep(rsD, writeregM),
                !rst && regwriteM && dep(rtD, writeregM),
                fa, fb, fh, dBusy};
        got  = {stallF, stallD, stallE, stallM, stallW, flushD, flushE, flushM,
                forwardaD, forwardbD, forwardaE, forwardbE, forwardhiloE, div_busy};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL outputs cycle=%0d got=%h want=%h", cyc, got, want);
        end
        total++;
        if (stall_cnt !== CNTW'(cntModel)) begin
            bad++;
            $display("FAIL stall_cnt cycle=%0d got=%0d want=%0d", cyc, stall_cnt, cntModel);
        end
    endtask

    // Move the model forward with the current inputs, then clock the DUT.
    task automatic advance();
        if (rst) begin
            busyLeft = 0; inFlush = 0; cntModel = 0;
        end else begin
            if (expStallD && cntModel < CNT_MAX) cntModel++;
            if (excM && !inFlush) begin
                inFlush = 1; busyLeft = 0;
            end else if (inFlush) begin
                inFlush = 0; busyLeft = 0;
            end else if (busyLeft == 0 && div_startE) begin
                busyLeft = DIV_LAT;
            end else if (busyLeft > 0) begin
                busyLeft--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        step();
        lit("rst_flushD", flushD, 1);
        lit("rst_stallF", stallF, 0);
        advance();
        rst = 0;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        @(posedge clk);
        #1;
        doReset();
        lit("reset_cnt", stall_cnt, 0);

        // Divide with DIV_LAT=4 that starts at cycle 0.
        clearInputs(); div_startE = 1;
        step(); lit("div_c0_stallE", stallE, 1); lit("div_c0_busy", div_busy, 0); advance();
        div_startE = 0;
        for (int c = 1; c <= 3; c++) begin
            step(); lit("div_hold_stallE", stallE, 1); lit("div_hold_busy", div_busy, 1); advance();
        end
        step(); lit("div_c4_stallE", stallE, 0); lit("div_c4_busy", div_busy, 1); advance();
        step(); lit("div_cnt", stall_cnt, 4); lit("div_c5_busy", div_busy, 0); advance();

        // Load-use stall, then the same pattern on $0.
        clearInputs(); memtoregE = 1; writeregE = 2; rsD = 2;
        step(); lit("lw_stallF", stallF, 1); lit("lw_stallD", stallD, 1); lit("lw_flushE", flushE, 1); advance();
        writeregE = 0; rsD = 0;
        step(); lit("lw0_stallD", stallD, 0); lit("lw0_flushE", flushE, 0); advance();

        // E-stage forwarding priority.
        clearInputs(); rsE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
        step(); lit("fwd_MW", forwardaE, 2); advance();
        regwriteM = 0;
        step(); lit("fwd_W", forwardaE, 1); advance();
        rsE = 0;
        step(); lit("fwd_zero", forwardaE, 0); advance();

        // Exception in DIV when dcnt=2.
        clearInputs(); div_startE = 1; step(); advance();
        div_startE = 0; step(); advance();
        excM = 1;
        step(); lit("exc_flushD", flushD, 1); lit("exc_flushE", flushE, 1); lit("exc_flushM", flushM, 1);
        lit("exc_stallE", stallE, 0); advance();
        step(); lit("flush_stallF", stallF, 1); lit("flush_flushD", flushD, 1); lit("flush_flushE", flushE, 0);
        lit("flush_busy", div_busy, 0); advance();
        excM = 0;
        step(); lit("post_stallE", stallE, 0); lit("post_flushD", flushD, 0); advance();

        // Reset in the middle of a divide.
        clearInputs(); div_startE = 1; step(); advance();
        div_startE = 0; rst = 1;
        step(); lit("rstdiv_stallE", stallE, 0); lit("rstdiv_busy", div_busy, 0); advance();
        rst = 0;
        step(); lit("rstdiv_after_stallE", stallE, 0); lit("rstdiv_cnt", stall_cnt, 0); advance();

        // Counter saturation: 9 stalls with a 3-bit counter.
        clearInputs(); memtoregE = 1; writeregE = 5; rtD = 5;
        for (int k = 0; k < 9; k++) begin
            step(); advance();
        end
        clearInputs();
        step(); lit("sat_cnt", stall_cnt, CNT_MAX); advance();

        // Randomized stream.
        for (int n = 0; n < 3000; n++) begin
            rst        = ($urandom_range(0, 59) == 0);
            rsD        = REGW'($urandom_range(0, 3));
            rtD        = REGW'($urandom_range(0, 3));
            rsE        = REGW'($urandom_range(0, 3));
            rtE        = REGW'($urandom_range(0, 3));
            writeregE  = REGW'($urandom_range(0, 3));
            writeregM  = REGW'($urandom_range(0, 3));
            writeregW  = REGW'($urandom_range(0, 3));
            branchD    = ($urandom_range(0, 3) == 0);
            regwriteE  = $urandom_range(0, 1) == 1;
            memtoregE  = ($urandom_range(0, 3) == 0);
            div_startE = ($urandom_range(0, 7) == 0);
            hiloreadE  = $urandom_range(0, 1) == 1;
            regwriteM  = $urandom_range(0, 1) == 1;
            memtoregM  = ($urandom_range(0, 3) == 0);
            hilowriteM = $urandom_range(0, 1) == 1;
            excM       = ($urandom_range(0, 19) == 0);
            regwriteW  = $urandom_range(0, 1) == 1;
            hilowriteW = $urandom_range(0, 1) == 1;
            step();
            advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
